// File: rtl/sat_corr_if.sv
// Sample stream in, integration results out, for the satellite correlator.
interface sat_corr_if;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned ACC_W    = 32;

  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] real_in;
  logic signed [SAMPLE_W-1:0] imag_in;
  logic                       dump_valid;
  logic                       dump_ready;
  logic signed [ACC_W-1:0]    dump_real;
  logic signed [ACC_W-1:0]    dump_imag;

  modport master (
    output sample_valid, real_in, imag_in, dump_ready,
    input  dump_valid, dump_real, dump_imag
  );

  modport slave (
    input  sample_valid, real_in, imag_in, dump_ready,
    output dump_valid, dump_real, dump_imag
  );
endinterface

// File: rtl/sat_corr.sv
// Single-channel GPS correlator: carrier and C/A code wipe-off followed by
// integrate-and-dump with a valid/ready result port and sticky overrun flag.
module sat_corr (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] freq,
  input  logic [15:0] dump_len,
  input  logic [5:0]  ca_sel,
  input  logic [35:0] ca_seq,
  input  logic        overrun_clr,
  output logic        busy,
  output logic        overrun,
  sat_corr_if.slave   bus
);
  localparam int unsigned PHASE_W = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ROT_W   = 17;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned CA_LEN  = 36;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;
  logic   go_c, abort_c, accept_c;

  logic [PHASE_W-1:0] phase_q;
  logic [CNT_W-1:0]   cnt_q, len_q;
  logic               last_c, code_c;

  logic signed [ROT_W-1:0] in_i_c, in_q_c, rot_i_c, rot_q_c;
  logic signed [ROT_W-1:0] s1_i_q, s1_q_q, s2_i_q, s2_q_q;
  logic                    s1_v_q, s1_code_q, s1_last_q;
  logic                    s2_v_q, s2_last_q;

  logic signed [ACC_W-1:0] acc_i_q, acc_q_q, sum_i_c, sum_q_c;
  logic signed [ACC_W-1:0] dump_i_q, dump_q_q;
  logic                    dump_valid_q, load_c;

  // Control FSM: stop has priority over start and over sample acceptance
  always_comb begin
    state_d  = state_q;
    go_c     = 1'b0;
    abort_c  = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop && (dump_len != '0)) begin
          state_d = RUN;
          go_c    = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          abort_c = 1'b1;
        end else begin
          accept_c = bus.sample_valid;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Carrier wipe-off: rotate the sample by -quadrant * 90 degrees
  always_comb begin
    in_i_c  = ROT_W'(bus.real_in);
    in_q_c  = ROT_W'(bus.imag_in);
    rot_i_c = in_i_c;
    rot_q_c = in_q_c;
    case (phase_q[PHASE_W-1 -: 2])
      2'd0: begin rot_i_c = in_i_c;  rot_q_c = in_q_c;  end
      2'd1: begin rot_i_c = in_q_c;  rot_q_c = -in_i_c; end
      2'd2: begin rot_i_c = -in_i_c; rot_q_c = -in_q_c; end
      default: begin rot_i_c = -in_q_c; rot_q_c = in_i_c; end
    endcase
  end

  always_comb begin
    code_c  = (ca_sel < 6'(CA_LEN)) ? ca_seq[ca_sel] : 1'b0;
    last_c  = ((cnt_q + CNT_W'(1)) == len_q);
    sum_i_c = acc_i_q + ACC_W'(s2_i_q);
    sum_q_c = acc_q_q + ACC_W'(s2_q_q);
    load_c  = s2_v_q && s2_last_q && !abort_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      busy         <= 1'b0;
      phase_q      <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      s1_v_q       <= 1'b0;
      s1_code_q    <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_i_q       <= '0;
      s1_q_q       <= '0;
      s2_v_q       <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_i_q       <= '0;
      s2_q_q       <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      dump_i_q     <= '0;
      dump_q_q     <= '0;
      dump_valid_q <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);

      // Sample bookkeeping: phase and per-integration count
      if (go_c) begin
        phase_q <= '0;
        cnt_q   <= '0;
        len_q   <= dump_len;
      end else if (accept_c) begin
        phase_q <= phase_q + freq;
        cnt_q   <= last_c ? '0 : cnt_q + CNT_W'(1);
      end else if (abort_c) begin
        cnt_q <= '0;
      end

      s1_v_q    <= accept_c;
      s1_code_q <= code_c;
      s1_last_q <= last_c;
      s1_i_q    <= rot_i_c;
      s1_q_q    <= rot_q_c;

      // Code wipe-off: chip value 1 flips the sample sign
      s2_v_q    <= s1_v_q && !abort_c;
      s2_last_q <= s1_last_q;
      s2_i_q    <= s1_code_q ? -s1_i_q : s1_i_q;
      s2_q_q    <= s1_code_q ? -s1_q_q : s1_q_q;

      if (abort_c || load_c) begin
        acc_i_q <= '0;
        acc_q_q <= '0;
      end else if (s2_v_q) begin
        acc_i_q <= sum_i_c;
        acc_q_q <= sum_q_c;
      end

      // Result register: a new load always wins, flagging an unaccepted predecessor
      if (load_c) begin
        dump_i_q     <= sum_i_c;
        dump_q_q     <= sum_q_c;
        dump_valid_q <= 1'b1;
      end else if (dump_valid_q && bus.dump_ready) begin
        dump_valid_q <= 1'b0;
      end

      if (load_c && dump_valid_q && !bus.dump_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_real  = dump_i_q;
  assign bus.dump_imag  = dump_q_q;
endmodule

// File: doc/sat_corr.md
SAT_CORR -- requirements
Module: sat_corr

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; IDLE -> RUN.
REQ-005 stop  in  1  one-cycle pulse; abort to IDLE.
REQ-006 freq  in  32  carrier phase increment per accepted sample; read live.
REQ-007 dump_len  in  16  samples per integration; latched on accepted start.
REQ-008 ca_sel  in  6  selects active code bit from ca_seq; read live.
REQ-009 ca_seq  in  36  per-satellite C/A chip vector from the code generator.
REQ-010 sample_valid  in  1  real_in/imag_in valid this cycle.
REQ-011 real_in, imag_in  in  16 each  signed baseband I/Q sample.
REQ-012 dump_valid  out  1  integration result available.
REQ-013 dump_ready  in  1  consumer accepts the result.
REQ-014 dump_real, dump_imag  out  32 each  signed integrated correlation.
REQ-015 busy  out  1  high in RUN.
REQ-016 overrun  out  1  sticky; a result was overwritten before acceptance.
REQ-017 overrun_clr  in  1  clears overrun.

Function
REQ-018 FSM states SHALL be IDLE and RUN; start with dump_len != 0 in IDLE -> RUN; start with dump_len == 0 ignored; start in RUN ignored.
REQ-019 stop in RUN -> IDLE next cycle; partial accumulation and in-flight pipeline samples discarded; a pending dump_valid result is kept.
REQ-020 stop and start in the same cycle: stop wins.
REQ-021 Samples SHALL be accepted only when sample_valid=1 and state=RUN (including the start cycle's successor, not the start cycle itself).
REQ-022 32-bit phase accumulator: cleared to 0 on accepted start; after each accepted sample phase += freq (mod 2^32); the sample uses the phase value before the increment.
REQ-023 Carrier wipe-off (stage 1, registered), q = phase[31:30]: q0 (I,Q); q1 (Q,-I); q2 (-I,-Q); q3 (-Q,I); results 17-bit signed, so -(-32768) = +32768 exactly.
REQ-024 Code wipe-off (stage 2, registered): c = ca_seq[ca_sel] sampled at acceptance; c=1 negates both components, c=0 passes.
REQ-025 Stage 3: 32-bit signed accumulators, sign-extended adds, no saturation (max |sum| 32768*65535 fits).
REQ-026 Sample counter increments per accepted sample; the sample that brings the count to dump_len is tagged last; counter wraps to 0 for the next integration with no sample lost.
REQ-027 When a tagged sample reaches stage 3 (3 cycles after acceptance), dump_real/dump_imag SHALL load acc+sample, accumulators SHALL load 0, and dump_valid SHALL be 1 from that cycle.
REQ-028 A sample accepted the cycle after the last sample SHALL add into the cleared accumulators.
REQ-029 dump_valid SHALL remain high with stable data until a cycle with dump_valid=1 and dump_ready=1, then drop the next cycle unless a new result loads in that same cycle.
REQ-030 If a new result loads while dump_valid=1 and not being accepted that cycle, the new result SHALL overwrite the old one and overrun SHALL be set.
REQ-031 overrun_clr and an overrun event in the same cycle: overrun stays 1.

Reset
REQ-032 reset SHALL force IDLE, phase=0, counter=0, accumulators=0, pipeline valids=0, dump_valid=0, dump_real=dump_imag=0, busy=0, overrun=0; reset overrides start, stop and all other inputs, including mid-integration.

Verification
REQ-033 freq=0, ca bit 0, dump_len=4, four samples (100,-50) -> dump_real=400, dump_imag=-200, dump_valid 3 cycles after the 4th acceptance.
REQ-034 Same stimulus with ca bit 1 -> dump_real=-400, dump_imag=200.
REQ-035 freq=0x40000000, dump_len=1, four back-to-back samples (100,0) -> results (100,0), (0,-100), (-100,0), (0,100) on consecutive cycles with dump_ready=1.
REQ-036 dump_ready=0 across two integrations -> overrun=1 and the second result is held; overrun_clr -> overrun=0.
REQ-037 stop after 2 of 4 samples, then start and 4 samples (1,1) -> only (4,4) is dumped; reset mid-RUN -> all outputs 0 the next cycle.
REQ-038 Samples (-32768,-32768) with ca bit 1, dump_len=65535 -> dump_real=dump_imag=2147450880.
